fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 192 +++++++++++++++++++
 tb/tb_fetch_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding memory read feeding a 2-entry buffer.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky HALT state.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misaligned
);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, FULL, DRAIN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;
`endif

    state_t      state_q, state_d;
    state_t      resume_state;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q    [DEPTH];

    logic [31:0] redir_pc;
    logic        redir;
    logic        push;
    logic        pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    logic halt_pend_q, halt_pend_d;
    logic redir_bad;

    // Once halted, redirects are ignored until reset.
    assign redir        = redirect_valid && (state_q != HALT);
    assign redir_pc     = redirect_pc;
    assign redir_bad    = redir && (redirect_pc[1:0] != 2'b00);
    assign resume_state = redir_bad ? HALT : REQ;
    assign misaligned   = misaligned_q;
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir        = redirect_valid;
    assign redir_pc     = {redirect_pc[31:2], 2'b00};
    assign resume_state = REQ;
    assign misaligned   = 1'b0;
`endif

    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];

    // A redirect squashes both the consumer handshake and any returning data.
    assign pop  = instr_valid && instr_ready && !redir;
    assign push = (state_q == REQ) && mem_ack && !redir && ((count_q != 2'd2) || pop);

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redir) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q || redir_bad;
        halt_pend_d  = halt_pend_q;
`endif
        mem_req      = 1'b0;
        mem_addr     = fetch_pc_q;

        if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redir) begin
            fetch_pc_d = redir_pc;
        end

        case (state_q)
            IDLE: begin
                state_d = resume_state;
            end
            REQ: begin
                mem_req = 1'b1;
                if (redir && !mem_ack) begin
                    // Remember the in-flight address so it stays on the bus until acked.
                    state_d      = DRAIN;
                    drain_addr_d = fetch_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
                    halt_pend_d  = redir_bad;
`endif
                end else if (redir) begin
                    state_d = resume_state;
                end else if (mem_ack && (count_d == 2'd2)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (redir || pop) begin
                    state_d = resume_state;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
                halt_pend_d = halt_pend_q || redir_bad;
                if (mem_ack) begin
                    state_d = (halt_pend_q || redir_bad) ? HALT : REQ;
                end
`else
                if (mem_ack) begin
                    state_d = REQ;
                end
`endif
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
            halt_pend_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
            halt_pend_q  <= halt_pend_d;
`endif
        end
    end

    // Buffer payload needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected buffer entries are queued when a
// fetch is acked and compared when the consumer pops the buffer head.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: returns a word derived from the requested address.
    assign mem_rdata = data_of(mem_addr);

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .misaligned     (misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc);
        q_pc.push_back(pc);
        q_data.push_back(data_of(pc));
    endtask

    // Leaves the DUT in its first REQ cycle (one IDLE cycle after reset release).
    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        q_pc.delete();
        q_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_ack = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
        reset = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_mem_req: got %b want 0", mem_req); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr = 32'h0;
        do_reset();
        mem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL stream_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, exp_addr); end
            total++; if (instr_valid !== (q_pc.size() != 0)) begin bad++; $display("FAIL stream_valid: got %b want %b", instr_valid, (q_pc.size() != 0)); end
            if (instr_valid && q_pc.size() != 0) begin
                total++; if (instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL stream_pop: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, q_pc[0], q_data[0]); end
                $display("stream pop pc=%h instr=%h", instr_pc, instr);
                void'(q_pc.pop_front()); void'(q_data.pop_front());
            end
            expect_push(exp_addr);
            exp_addr += 32'd4;
            tick();
        end
        mem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_full();
        int n;
        do_reset();
        mem_ack = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin bad++; $display("FAIL full_fill_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, 32'(4 * i)); end
            expect_push(32'(4 * i));
            tick();
        end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_no_req: got %b want 0", mem_req); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== q_pc[0]) begin bad++; $display("FAIL full_head: got valid=%b pc=%h want valid=1 pc=%h", instr_valid, instr_pc, q_pc[0]); end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_hold: got %b want 0", mem_req); end
        instr_ready = 1'b1;
        total++; if (instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL full_pop: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, q_pc[0], q_data[0]); end
        void'(q_pc.pop_front()); void'(q_data.pop_front());
        tick();
        instr_ready = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr); end
        expect_push(32'h8);
        tick();
        mem_ack = 1'b0; instr_ready = 1'b1;
        n = 0;
        while (q_pc.size() != 0 && n < 4) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL full_drain: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", instr_valid, instr_pc, instr, q_pc[0], q_data[0]); end
            $display("full pop pc=%h", instr_pc);
            void'(q_pc.pop_front()); void'(q_data.pop_front());
            tick();
            n++;
        end
        total++; if (instr_valid !== 1'b0 || q_pc.size() != 0) begin bad++; $display("FAIL full_empty: got valid=%b left=%0d want valid=0 left=0", instr_valid, q_pc.size()); end
        instr_ready = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        instr_ready = 1'b1; mem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL drain_hold: got req=%b addr=%h valid=%b want req=1 addr=00000000 valid=0", mem_req, mem_addr, instr_valid); end
            tick();
        end
        mem_ack = 1'b1;
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL drain_ack_addr: got %h want 00000000", mem_addr); end
        tick();
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL drain_resume: got req=%b addr=%h valid=%b want req=1 addr=00000100 valid=0", mem_req, mem_addr, instr_valid); end
        mem_ack = 1'b1;
        expect_push(32'h100);
        tick();
        mem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL drain_first: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", instr_valid, instr_pc, instr, q_pc[0], q_data[0]); end
        void'(q_pc.pop_front()); void'(q_data.pop_front());
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL drain_popped: got %b want 0", instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_in_drain();
        logic [31:0] targets [3];
        targets[0] = 32'h80; targets[1] = 32'h200; targets[2] = 32'h300;
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = 1'b1; redirect_pc = targets[i];
            tick();
        end
        redirect_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL redir2_hold: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (mem_addr !== 32'h300 || instr_valid !== 1'b0) begin bad++; $display("FAIL redir2_last_wins: got addr=%h valid=%b want addr=00000300 valid=0", mem_addr, instr_valid); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        mem_ack = 1'b1; instr_ready = 1'b0;
        tick(); tick();
        mem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h500; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        total++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h500) begin bad++; $display("FAIL redir_full: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000500", instr_valid, mem_req, mem_addr); end
        mem_ack = 1'b1;
        expect_push(32'h500);
        tick();
        mem_ack = 1'b0; instr_ready = 1'b1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL redir_full_head: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", instr_valid, instr_pc, instr, q_pc[0], q_data[0]); end
        void'(q_pc.pop_front()); void'(q_data.pop_front());
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_full_flushed: got %b want 0", instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        mem_ack = 1'b1; instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (mem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin bad++; $display("FAIL wrap_start: got addr=%h valid=%b want addr=fffffffc valid=0", mem_addr, instr_valid); end
        expect_push(32'hFFFF_FFFC);
        tick();
        mem_ack = 1'b0;
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", mem_addr); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== q_pc[0] || instr !== q_data[0]) begin bad++; $display("FAIL wrap_head: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", instr_valid, instr_pc, instr, q_pc[0], q_data[0]); end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL midreset_pre: got %h want 00000004", mem_addr); end
        reset = 1'b1;
        tick();
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL midreset: got req=%b addr=%h valid=%b want req=0 addr=00000000 valid=0", mem_req, mem_addr, instr_valid); end
        reset = 1'b0;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL midreset_restart: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        mem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        total++; if (misaligned !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL mis_flag: got mis=%b req=%b addr=%h want mis=1 req=1 addr=00000000", misaligned, mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = (i == 1); redirect_pc = 32'h40;
            total++; if (mem_req !== 1'b0 || misaligned !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL mis_halt: got req=%b mis=%b valid=%b want req=0 mis=1 valid=0", mem_req, misaligned, instr_valid); end
            tick();
        end
        redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (misaligned !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL mis_reset: got mis=%b req=%b want mis=0 req=0", misaligned, mem_req); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL mis_restart: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
`else
        total++; if (misaligned !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL mis_drain: got mis=%b req=%b addr=%h want mis=0 req=1 addr=00000000", misaligned, mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (misaligned !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL mis_forced_align: got mis=%b req=%b addr=%h want mis=0 req=1 addr=00000100", misaligned, mem_req, mem_addr); end
`endif
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_ack = 1'b0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_redirect_in_drain();
        test_redirect_full();
        test_wrap();
        test_reset_mid_request();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
